// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard / forwarding controller.
package pipe_hazard_pkg;

    // Tag rd field is sized for the widest register file this block supports;
    // narrower register addresses are zero-extended into it.
    localparam int unsigned TAG_RD_W = 8;

    // Forward select value meaning "use the register-file operand".
    localparam int unsigned FWD_RF = 0;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                we;
        logic                is_load;
        logic                is_halt;
    } hz_tag_t;

    // Width of a forward select able to encode 0..stages.
    function automatic int unsigned fwd_w(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hazard_operand_match.sv
// Compares one ID source register against the in-flight tag vector and reports
// the youngest producing stage and whether its result can be forwarded in time.
module hazard_operand_match
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 4,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic [REG_AW-1:0]         rs,
    input  logic                      rs_used,
    input  hz_tag_t [STAGES:1]        tags,
    output logic                      hit,
    output logic [fwd_w(STAGES)-1:0]  stage,
    output logic                      avail
);

    localparam int unsigned FW = fwd_w(STAGES);

    logic [TAG_RD_W-1:0] rs_ext;
    logic                rs_skip;

    // Only a subset of each tag is inspected here (stage STAGES never forwards).
    logic unused_tags;
    assign unused_tags = ^tags;

    // Zero-extend the source so it compares against the full tag rd field.
    always_comb begin
        rs_ext             = '0;
        rs_ext[REG_AW-1:0] = rs;
    end

    assign rs_skip = !rs_used || ((ZERO_REG != 0) && (rs == '0));

    // Scan oldest to youngest so the youngest (smallest stage) match wins.
    // A match at the last stage is ignored: the register file bypasses it.
    always_comb begin
        hit   = 1'b0;
        stage = '0;
        avail = 1'b0;
        if (!rs_skip) begin
            for (int s = STAGES - 1; s >= 1; s--) begin
                if (tags[s].valid && tags[s].we && (tags[s].rd == rs_ext)) begin
                    hit   = 1'b1;
                    stage = FW'(s);
                    // Producer sits at s+1 next cycle; usable once past its ready stage.
                    avail = tags[s].is_load ? ((s + 1) > int'(LOAD_STAGE)) : ((s + 1) > 1);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and halt-drain controller for the in-order pipeline.
// Tracks destination tags for STAGES post-decode stages (1 = EX, STAGES = WB).
// LOAD_STAGE must lie in 1..STAGES and REG_AW must not exceed TAG_RD_W.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 4,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         id_rs1,
    input  logic [REG_AW-1:0]         id_rs2,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_rd_we,
    input  logic                      id_is_load,
    input  logic                      id_is_halt,
    input  logic                      ex_redirect,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      flush_id,
    output logic                      ex_bubble,
    output logic [fwd_w(STAGES)-1:0]  ex_fwd1,
    output logic [fwd_w(STAGES)-1:0]  ex_fwd2,
    output logic                      hlt
);

    localparam int unsigned FW = fwd_w(STAGES);

    hz_tag_t [STAGES:1] tags_q, tags_d;
    logic               halt_pend_q, halt_pend_d;
    logic               hlt_q, hlt_d;
    logic [FW-1:0]      ex_fwd1_q, ex_fwd1_d;
    logic [FW-1:0]      ex_fwd2_q, ex_fwd2_d;

    logic          hit1, hit2, avail1, avail2;
    logic [FW-1:0] stage1, stage2;
    logic          id_act, use_stall, stall, accept, halt_enter;
    hz_tag_t       id_tag;

    hazard_operand_match #(
        .REG_AW     (REG_AW),
        .STAGES     (STAGES),
        .LOAD_STAGE (LOAD_STAGE),
        .ZERO_REG   (ZERO_REG)
    ) u_match_rs1 (
        .rs      (id_rs1),
        .rs_used (id_rs1_used),
        .tags    (tags_q),
        .hit     (hit1),
        .stage   (stage1),
        .avail   (avail1)
    );

    hazard_operand_match #(
        .REG_AW     (REG_AW),
        .STAGES     (STAGES),
        .LOAD_STAGE (LOAD_STAGE),
        .ZERO_REG   (ZERO_REG)
    ) u_match_rs2 (
        .rs      (id_rs2),
        .rs_used (id_rs2_used),
        .tags    (tags_q),
        .hit     (hit2),
        .stage   (stage2),
        .avail   (avail2)
    );

    // Once a halt is accepted, nothing further from ID may enter the pipe.
    assign id_act    = id_valid && !halt_pend_q;
    assign use_stall = id_act && ((hit1 && !avail1) || (hit2 && !avail2));
    // A redirect kills the ID instruction, so it overrides any stall.
    assign stall     = use_stall && !ex_redirect;
    assign accept    = id_act && !stall && !ex_redirect;

    assign stall_if  = stall || halt_pend_q;
    assign stall_id  = stall;
    assign flush_id  = ex_redirect;
    assign ex_bubble = stall || ex_redirect || halt_pend_q;

    assign ex_fwd1 = ex_fwd1_q;
    assign ex_fwd2 = ex_fwd2_q;
    assign hlt     = hlt_q;

    // Build the ID tag from the decode fields.
    always_comb begin
        id_tag                = '0;
        id_tag.valid          = 1'b1;
        id_tag.rd[REG_AW-1:0] = id_rd;
        id_tag.we             = id_rd_we;
        id_tag.is_load        = id_is_load;
        id_tag.is_halt        = id_is_halt;
    end

    // Shift the tag pipe; stage 1 gets the accepted ID tag or a bubble.
    always_comb begin
        tags_d[1] = accept ? id_tag : '0;
        for (int k = 2; k <= STAGES; k++) begin
            tags_d[k] = tags_q[k-1];
        end
    end

    // hlt rises on the same edge the halt tag lands in the last stage.
    if (STAGES > 1) begin : g_halt_multi
        assign halt_enter = tags_q[STAGES-1].valid && tags_q[STAGES-1].is_halt;
    end else begin : g_halt_single
        assign halt_enter = tags_d[1].valid && tags_d[1].is_halt;
    end

    // Next-state for halt tracking and the registered forward selects.
    always_comb begin
        halt_pend_d = halt_pend_q || (accept && id_is_halt);
        hlt_d       = hlt_q || halt_enter;
        ex_fwd1_d   = FW'(FWD_RF);
        ex_fwd2_d   = FW'(FWD_RF);
        if (accept) begin
            if (hit1) ex_fwd1_d = stage1 + FW'(1);
            if (hit2) ex_fwd2_d = stage2 + FW'(1);
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags_q      <= '0;
            halt_pend_q <= 1'b0;
            hlt_q       <= 1'b0;
            ex_fwd1_q   <= '0;
            ex_fwd2_q   <= '0;
        end else begin
            tags_q      <= tags_d;
            halt_pend_q <= halt_pend_d;
            hlt_q       <= hlt_d;
            ex_fwd1_q   <= ex_fwd1_d;
            ex_fwd2_q   <= ex_fwd2_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl at default parameters.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_rd_we, id_is_load, id_is_halt;
    logic       ex_redirect;
    logic       stall_if, stall_id, flush_id, ex_bubble, hlt;
    logic [1:0] ex_fwd1, ex_fwd2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW     (4),
        .STAGES     (3),
        .LOAD_STAGE (2),
        .ZERO_REG   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_rd_we    (id_rd_we),
        .id_is_load  (id_is_load),
        .id_is_halt  (id_is_halt),
        .ex_redirect (ex_redirect),
        .stall_if    (stall_if),
        .stall_id    (stall_id),
        .flush_id    (flush_id),
        .ex_bubble   (ex_bubble),
        .ex_fwd1     (ex_fwd1),
        .ex_fwd2     (ex_fwd2),
        .hlt         (hlt)
    );

    task automatic set_id(input logic v, input logic [3:0] rs1, input logic u1,
                          input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                          input logic we, input logic ld, input logic ht);
        id_valid = v;   id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd    = rd;  id_rd_we = we; id_is_load = ld; id_is_halt = ht;
    endtask

    task automatic id_idle();
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        id_idle();
        ex_redirect = 1'b0;
        rst = 1'b1;
        adv();
        rst = 1'b0;
    endtask

    // {stall_if, stall_id, flush_id, ex_bubble}
    function automatic logic [3:0] ctl();
        return {stall_if, stall_id, flush_id, ex_bubble};
    endfunction

    task automatic test_reset();
        id_idle();
        ex_redirect = 1'b0;
        rst = 1'b1;
        #2;
        n_vec++;
        if ({ctl(), ex_fwd1, ex_fwd2, hlt} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", {ctl(), ex_fwd1, ex_fwd2, hlt}, 9'b0);
        end
        adv();
        rst = 1'b0;
        ex_redirect = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctl() !== 4'b0011) begin
            n_err++;
            $display("FAIL reset_redirect_only: got %b want %b", ctl(), 4'b0011);
        end
        ex_redirect = 1'b0;
        adv();
    endtask

    task automatic test_fwd_alu();
        do_reset();
        set_id(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);  // ADD R1,R2,R3
        adv();
        set_id(1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);  // SUB R2,R1,R5
        @(negedge clk);
        n_vec++;
        if (ctl() !== 4'b0000) begin
            n_err++;
            $display("FAIL fwd_alu_no_stall: got %b want %b", ctl(), 4'b0000);
        end
        adv();
        id_idle();
        @(negedge clk);
        n_vec++;
        if ({ex_fwd1, ex_fwd2} !== {2'd2, 2'd0}) begin
            n_err++;
            $display("FAIL fwd_alu_sel: got %0d/%0d want 2/0", ex_fwd1, ex_fwd2);
        end
        adv();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);  // LW R3
        adv();
        set_id(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);  // ADD R4,R3,R3
        @(negedge clk);
        n_vec++;
        if (ctl() !== 4'b1101) begin
            n_err++;
            $display("FAIL load_use_stall: got %b want %b", ctl(), 4'b1101);
        end
        adv();
        @(negedge clk);
        n_vec++;
        if (ctl() !== 4'b0000) begin
            n_err++;
            $display("FAIL load_use_release: got %b want %b", ctl(), 4'b0000);
        end
        n_vec++;
        if ({ex_fwd1, ex_fwd2} !== 4'b0000) begin
            n_err++;
            $display("FAIL load_use_bubble_fwd: got %0d/%0d want 0/0", ex_fwd1, ex_fwd2);
        end
        adv();
        id_idle();
        @(negedge clk);
        n_vec++;
        if ({ex_fwd1, ex_fwd2} !== {2'd3, 2'd3}) begin
            n_err++;
            $display("FAIL load_use_fwd: got %0d/%0d want 3/3", ex_fwd1, ex_fwd2);
        end
        adv();
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);  // LW R0 (would stall)
        adv();
        set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);  // SUB R2,R0,R0
        @(negedge clk);
        n_vec++;
        if (ctl() !== 4'b0000) begin
            n_err++;
            $display("FAIL zero_reg_no_stall: got %b want %b", ctl(), 4'b0000);
        end
        adv();
        id_idle();
        @(negedge clk);
        n_vec++;
        if ({ex_fwd1, ex_fwd2} !== 4'b0000) begin
            n_err++;
            $display("FAIL zero_reg_fwd: got %0d/%0d want 0/0", ex_fwd1, ex_fwd2);
        end
        adv();
    endtask

    task automatic test_youngest();
        do_reset();
        set_id(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);  // ADD R4
        adv();
        set_id(1'b1, 4'd6, 1'b1, 4'd7, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);  // ADD R4
        adv();
        set_id(1'b1, 4'd4, 1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);  // XOR R5,R4,R1
        adv();
        id_idle();
        @(negedge clk);
        n_vec++;
        if ({ex_fwd1, ex_fwd2} !== {2'd2, 2'd0}) begin
            n_err++;
            $display("FAIL youngest_wins: got %0d/%0d want 2/0", ex_fwd1, ex_fwd2);
        end
        // Producer two ahead forwards from stage 3.
        set_id(1'b1, 4'd2, 1'b1, 4'd3, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);  // ADD R6
        adv();
        id_idle();
        adv();
        set_id(1'b1, 4'd7, 1'b1, 4'd6, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0);  // uses R6 on rs2
        adv();
        id_idle();
        @(negedge clk);
        n_vec++;
        if ({ex_fwd1, ex_fwd2} !== {2'd0, 2'd3}) begin
            n_err++;
            $display("FAIL two_ahead_fwd: got %0d/%0d want 0/3", ex_fwd1, ex_fwd2);
        end
        // Producer three ahead needs no forward.
        set_id(1'b1, 4'd2, 1'b1, 4'd3, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0);  // ADD R9
        adv();
        id_idle();
        adv();
        adv();
        set_id(1'b1, 4'd9, 1'b1, 4'd9, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0);
        adv();
        id_idle();
        @(negedge clk);
        n_vec++;
        if ({ex_fwd1, ex_fwd2} !== 4'b0000) begin
            n_err++;
            $display("FAIL three_ahead_fwd: got %0d/%0d want 0/0", ex_fwd1, ex_fwd2);
        end
        adv();
    endtask

    task automatic test_redirect_vs_stall();
        do_reset();
        set_id(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);  // LW R3
        adv();
        set_id(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        ex_redirect = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctl() !== 4'b0011) begin
            n_err++;
            $display("FAIL redirect_beats_stall: got %b want %b", ctl(), 4'b0011);
        end
        adv();
        ex_redirect = 1'b0;
        id_idle();
        @(negedge clk);
        n_vec++;
        if ({ex_fwd1, ex_fwd2} !== 4'b0000) begin
            n_err++;
            $display("FAIL redirect_killed_fwd: got %0d/%0d want 0/0", ex_fwd1, ex_fwd2);
        end
        adv();
    endtask

    task automatic test_redirect_halt();
        do_reset();
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);  // HLT
        ex_redirect = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctl() !== 4'b0011) begin
            n_err++;
            $display("FAIL redirect_halt_ctl: got %b want %b", ctl(), 4'b0011);
        end
        adv();
        ex_redirect = 1'b0;
        id_idle();
        @(negedge clk);
        n_vec++;
        if (ctl() !== 4'b0000) begin
            n_err++;
            $display("FAIL redirect_halt_no_pend: got %b want %b", ctl(), 4'b0000);
        end
        for (int i = 0; i < 4; i++) adv();
        @(negedge clk);
        n_vec++;
        if (hlt !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_halt_hlt: got %b want %b", hlt, 1'b0);
        end
        adv();
    endtask

    task automatic test_halt_drain();
        do_reset();
        set_id(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);  // ADD R1
        adv();
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);  // HLT
        @(negedge clk);
        n_vec++;
        if (ctl() !== 4'b0000) begin
            n_err++;
            $display("FAIL halt_accept_ctl: got %b want %b", ctl(), 4'b0000);
        end
        adv();  // HLT now in EX
        set_id(1'b1, 4'd1, 1'b1, 4'd1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0);  // ignored
        @(negedge clk);
        n_vec++;
        if ({ctl(), hlt} !== 5'b10010) begin
            n_err++;
            $display("FAIL halt_pend_1: got %b want %b", {ctl(), hlt}, 5'b10010);
        end
        adv();
        @(negedge clk);
        n_vec++;
        if ({ctl(), hlt} !== 5'b10010) begin
            n_err++;
            $display("FAIL halt_pend_2: got %b want %b", {ctl(), hlt}, 5'b10010);
        end
        adv();
        @(negedge clk);
        n_vec++;
        if (hlt !== 1'b1) begin
            n_err++;
            $display("FAIL halt_rise: got %b want %b", hlt, 1'b1);
        end
        adv();
        adv();
        @(negedge clk);
        n_vec++;
        if ({stall_if, hlt} !== 2'b11) begin
            n_err++;
            $display("FAIL halt_sticky: got %b want %b", {stall_if, hlt}, 2'b11);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({stall_if, hlt} !== 2'b00) begin
            n_err++;
            $display("FAIL halt_async_reset: got %b want %b", {stall_if, hlt}, 2'b00);
        end
        adv();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);  // HLT
        adv();
        id_idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({ctl(), hlt} !== 5'b00000) begin
            n_err++;
            $display("FAIL mid_drain_reset: got %b want %b", {ctl(), hlt}, 5'b00000);
        end
        adv();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) adv();
        @(negedge clk);
        n_vec++;
        if ({stall_if, hlt} !== 2'b00) begin
            n_err++;
            $display("FAIL mid_drain_tags_cleared: got %b want %b", {stall_if, hlt}, 2'b00);
        end
        adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        id_idle();
        ex_redirect = 1'b0;
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_zero_reg();
        test_youngest();
        test_redirect_vs_stall();
        test_redirect_halt();
        test_halt_drain();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard, forwarding and halt-drain controller for the in-order pipelined CPU. It sits beside the IF/ID and ID/EX pipeline registers and tracks in-flight destination tags across a configurable number of post-decode stages. It generates stall, flush, bubble and registered operand-forward selects, resolves taken-branch redirects, and drains the pipe on HLT before asserting `hlt`.

## Interface
- `REG_AW`, 4: register address width.
- `STAGES`, 3: post-decode stages tracked; stage 1 = EX, stage `STAGES` = WB.
- `LOAD_STAGE`, 2: stage at whose end load data becomes forwardable; legal range 1..`STAGES`.
- `ZERO_REG`, 1: when 1, register 0 never matches or forwards.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in `REG_AW`: ID source registers.
- `id_rs1_used`, `id_rs2_used` in 1: the source is actually read.
- `id_rd` in `REG_AW`, `id_rd_we` in 1: ID destination and write enable.
- `id_is_load`, `id_is_halt` in 1: ID is LW / HLT.
- `ex_redirect` in 1: instruction in EX resolved a taken branch this cycle.
- `stall_if`, `stall_id` out 1: hold PC / hold IF/ID.
- `flush_id` out 1: load NOP into IF/ID.
- `ex_bubble` out 1: load NOP into ID/EX.
- `ex_fwd1`, `ex_fwd2` out `$clog2(STAGES+1)`: registered; 0 = register-file value, k = result of stage k.
- `hlt` out 1: sticky halt.

## Operation
- Tag pipe `t[1..STAGES]`, each tag `{valid, rd, we, is_load, is_halt}`. It shifts every cycle: `t[k+1] <= t[k]`, and `t[1]` receives the ID tag or a bubble.
- Match for each used source: the smallest `s` in 1..`STAGES-1` with `t[s].valid & t[s].we & t[s].rd == rs`, skipping rs = 0 when `ZERO_REG`. The youngest match wins. A match only at `STAGES` needs no forward, because the register file bypasses internally.
- Availability: the producer will be at stage `s+1` next cycle. It is forwardable if `s+1 > avail`, where avail = `LOAD_STAGE` for loads and 1 otherwise.
  - Forwardable: `ex_fwd` <= `s+1`.
  - Not forwardable: load-use stall.
- Stall (`id_valid` & unforwardable match & !`ex_redirect`):
  - `stall_if` = `stall_id` = `ex_bubble` = 1.
  - `t[1]` <= bubble; `ex_fwd*` <= 0.
- Redirect (`ex_redirect`): `flush_id` = `ex_bubble` = 1, `t[1]` <= bubble, and any stall is suppressed. Redirect beats stall and beats halt acceptance.
- Halt:
  - HLT in ID, not stalled, not redirected: it is accepted and `halt_pend` is set.
  - While `halt_pend`: `stall_if` = 1, and ID is treated as invalid (bubbles only).
  - `hlt` <= 1 when the halt tag enters `t[STAGES]`, sticky until `rst`.
- Outputs `stall_*`, `flush_id` and `ex_bubble` are combinational from registered state plus ID/redirect inputs.

## Timing
- Reset: all tags invalid, `halt_pend` = 0, `ex_fwd*` = 0, `hlt` = 0, so every combinational output is 0 apart from input-driven terms.
- Load-use stall lasts exactly `LOAD_STAGE` − `s` cycles (1 for the defaults). Re-evaluation happens every cycle as tags shift.
- `ex_fwd*` is valid in the cycle the consumer occupies EX, one clock after decode acceptance.
- `hlt` rises `STAGES` − 1 cycles after the cycle `t[1]` captures HLT (2 cycles for the defaults).
- Reset mid-drain clears `halt_pend`, `hlt` and all tags immediately.
- Simultaneous stall and redirect: flush only.
- Redirect with HLT in ID: HLT killed, `halt_pend` stays 0.

## Structure
- Package `pipe_hazard_pkg`:
  - `hz_tag_t` struct.
  - `FWD_RF = 0`.
  - `fwd_w(STAGES)` width function.
- Sub-module `hazard_operand_match`: one source versus the tag vector. Outputs `hit`, `stage`, `avail`. Instantiated twice.

## Test plan
Defaults `STAGES=3`, `LOAD_STAGE=2`:
- ADD R1 then SUB R2,R1,R5 back-to-back -> no stall; `ex_fwd1` = 2 while SUB is in EX.
- LW R3 then ADD R4,R3,R3 -> `stall_if`/`stall_id`/`ex_bubble` = 1 for exactly one cycle; then `ex_fwd1` = `ex_fwd2` = 3.
- ADD R0 then SUB R2,R0,R0 with `ZERO_REG=1` -> no stall, `ex_fwd*` = 0.
- ADD R4, ADD R4, then XOR R5,R4,R1 -> youngest wins, `ex_fwd1` = 2; a producer three ahead gives `ex_fwd1` = 0.
- Load-use pair with `ex_redirect` = 1 in the same cycle -> `stall_*` = 0, `flush_id` = 1, `ex_bubble` = 1.
- ADD, HLT -> `stall_if` held from acceptance, `hlt` = 1 two cycles after HLT enters EX and stays high; assert `rst` mid-drain -> `hlt` = 0 immediately.
